// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, one bit per clock.
// A carry flop closes the loop; start/busy/done handshake around it.
module full_adder (
    input  logic in1,
    input  logic in2,
    input  logic cin,
    output logic sum,
    output logic carry
);
    assign sum   = in1 ^ in2 ^ cin;
    assign carry = (in1 & in2) | (cin & (in1 ^ in2));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] racc;
    logic             c;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] w_racc_nxt;
    logic             w_sum;
    logic             w_carry;

    full_adder u_fa (
        .in1   (ra[0]),
        .in2   (rb[0]),
        .cin   (c),
        .sum   (w_sum),
        .carry (w_carry)
    );

    // Result bits enter at the MSB and drift down to their final position
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_racc_nxt = w_sum;
        end else begin : g_wn
            assign w_racc_nxt = {w_sum, racc[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ra      <= '0;
            rb      <= '0;
            racc    <= '0;
            c       <= 1'b0;
            cnt     <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        ra      <= a;
                        rb      <= b;
                        c       <= cin;
                        cnt     <= '0;
                        racc    <= '0;
                        busy    <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    racc <= w_racc_nxt;
                    sum  <= w_racc_nxt;
                    c    <= w_carry;
                    ra   <= ra >> 1;
                    rb   <= rb >> 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        cout    <= w_carry;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule
